// File: rtl/reset_seq_pkg.sv
// Shared state encoding and default timing for the reset release sequencer.
// Top level and testbench both take their defaults from here.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_HOLD   = 2'd1,
        ST_STALL  = 2'd2,
        ST_RUN    = 2'd3
    } seq_state_e;

    localparam int DEF_SYNC_STAGES  = 2;
    localparam int DEF_MIN_ASSERT   = 10;
    localparam int DEF_HOLD_CYCLES  = 16;
    localparam int DEF_STALL_CYCLES = 8;
    localparam int DEF_CNT_W        = 8;

endpackage

// File: rtl/sync_chain.sv
// Plain flop-chain synchroniser for a single asynchronous bit.
// Reset value is a parameter so reset-type inputs can come up asserted.
module sync_chain #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/reset_release_sequencer.sv
// Qualifies the board reset request and releases the core in order:
// CoreBReset low after a hold window, then RunStall low and Ready high.
module reset_release_sequencer
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int MIN_ASSERT   = DEF_MIN_ASSERT,
    parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
    parameter int STALL_CYCLES = DEF_STALL_CYCLES,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             BResetN,
    input  logic             BResetIn,
    input  logic             ClearErr,
    output logic             CoreBReset,
    output logic             RunStall,
    output logic             Ready,
    output logic             ShortPulse,
    output logic [CNT_W-1:0] ResetCount
);

    localparam int ACNT_W = $clog2(MIN_ASSERT + 1);
    localparam int HCNT_W = $clog2(HOLD_CYCLES + 1);
    localparam int SCNT_W = $clog2(STALL_CYCLES + 1);

    localparam logic [ACNT_W-1:0] ACNT_MAX   = ACNT_W'(MIN_ASSERT);
    localparam logic [HCNT_W-1:0] HCNT_LAST  = HCNT_W'(HOLD_CYCLES - 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST  = SCNT_W'(STALL_CYCLES - 1);

    logic rs;

    sync_chain #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk_i  (CLK),
        .rst_ni (BResetN),
        .d_i    (BResetIn),
        .q_o    (rs)
    );

    seq_state_e        state_q, state_d;
    logic [ACNT_W-1:0] acnt_q, acnt_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic              por_q, por_d;
    logic              sp_q, sp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              core_q, stall_q, ready_q;

    always_comb begin
        state_d = state_q;
        acnt_d  = acnt_q;
        hcnt_d  = hcnt_q;
        scnt_d  = scnt_q;
        por_d   = por_q;
        cnt_d   = cnt_q;
        // A same-edge short-pulse set below overrides this clear.
        sp_d    = sp_q & ~ClearErr;

        unique case (state_q)
            ST_ASSERT: begin
                if (acnt_q != ACNT_MAX) acnt_d = acnt_q + 1'b1;
                if (!rs) begin
                    state_d = ST_HOLD;
                    hcnt_d  = '0;
                    if (!por_q) begin
                        if (acnt_q < ACNT_MAX) sp_d = 1'b1;
                        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    end
                    por_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (rs) begin
                    state_d = ST_ASSERT;
                    acnt_d  = '0;
                end else if (hcnt_q == HCNT_LAST) begin
                    state_d = ST_STALL;
                    scnt_d  = '0;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            ST_STALL: begin
                if (rs) begin
                    state_d = ST_ASSERT;
                    acnt_d  = '0;
                end else if (scnt_q == SCNT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (rs) begin
                    state_d = ST_ASSERT;
                    acnt_d  = '0;
                end
            end
            default: state_d = ST_ASSERT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!BResetN) begin
            state_q <= ST_ASSERT;
            acnt_q  <= '0;
            hcnt_q  <= '0;
            scnt_q  <= '0;
            por_q   <= 1'b1;
            sp_q    <= 1'b0;
            cnt_q   <= '0;
            core_q  <= 1'b1;
            stall_q <= 1'b1;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acnt_q  <= acnt_d;
            hcnt_q  <= hcnt_d;
            scnt_q  <= scnt_d;
            por_q   <= por_d;
            sp_q    <= sp_d;
            cnt_q   <= cnt_d;
            // Outputs follow the next state so they move on the same edge.
            core_q  <= (state_d == ST_ASSERT) || (state_d == ST_HOLD);
            stall_q <= (state_d != ST_RUN);
            ready_q <= (state_d == ST_RUN);
        end
    end

    assign CoreBReset = core_q;
    assign RunStall   = stall_q;
    assign Ready      = ready_q;
    assign ShortPulse = sp_q;
    assign ResetCount = cnt_q;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Random and directed stimulus against a time-since-request reference model.
// A second instance with a 2-bit episode counter exercises saturation.
module tb_reset_release_sequencer;
    import reset_seq_pkg::*;

    localparam int SYNC  = DEF_SYNC_STAGES;
    localparam int MINA  = DEF_MIN_ASSERT;
    localparam int HOLD  = DEF_HOLD_CYCLES;
    localparam int STALL = DEF_STALL_CYCLES;

    logic       CLK = 1'b0;
    logic       BResetN = 1'b0;
    logic       BResetIn = 1'b0;
    logic       ClearErr = 1'b0;
    logic       CoreBReset, RunStall, Ready, ShortPulse;
    logic [7:0] ResetCount;
    logic       CoreBReset2, RunStall2, Ready2, ShortPulse2;
    logic [1:0] ResetCount2;

    always #5 CLK = ~CLK;

    reset_release_sequencer dut (
        .CLK(CLK), .BResetN(BResetN), .BResetIn(BResetIn), .ClearErr(ClearErr),
        .CoreBReset(CoreBReset), .RunStall(RunStall), .Ready(Ready),
        .ShortPulse(ShortPulse), .ResetCount(ResetCount)
    );

    reset_release_sequencer #(.CNT_W(2)) dut2 (
        .CLK(CLK), .BResetN(BResetN), .BResetIn(BResetIn), .ClearErr(ClearErr),
        .CoreBReset(CoreBReset2), .RunStall(RunStall2), .Ready(Ready2),
        .ShortPulse(ShortPulse2), .ResetCount(ResetCount2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: k = edges since the synchronised request was last seen high.
    int   k = 0;
    int   run = 0;
    int   cnt = 0;
    int   since_rst = 0;
    bit   por = 1'b1;
    bit   sp = 1'b0;
    logic hist[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge(input logic b, input logic rn, input logic c);
        logic rs;
        bit   set;
        if (!rn) begin
            since_rst = 0;
            k = 0; run = 0; cnt = 0; por = 1'b1; sp = 1'b0;
        end else begin
            since_rst++;
            rs  = (since_rst <= SYNC || hist.size() < SYNC) ? 1'b1 : hist[hist.size() - SYNC];
            set = 1'b0;
            if (rs) begin
                run = (k == 0) ? run + 1 : 1;
                k   = 0;
            end else begin
                if (k == 0) begin
                    if (!por) begin
                        if (cnt < 255) cnt++;
                        if (run < MINA) set = 1'b1;
                    end
                    por = 1'b0;
                end
                if (k < 100000) k++;
            end
            if (set) sp = 1'b1;
            else if (c) sp = 1'b0;
        end
        hist.push_back(b);
        if (hist.size() > 8) void'(hist.pop_front());
    endtask

    task automatic step(input logic b, input logic rn, input logic c);
        @(negedge CLK);
        BResetIn = b; BResetN = rn; ClearErr = c;
        @(posedge CLK);
        cyc++;
        model_edge(b, rn, c);
        #1;
        check("CoreBReset", 32'(CoreBReset), 32'(k <= HOLD));
        check("RunStall",   32'(RunStall),   32'(k <= HOLD + STALL));
        check("Ready",      32'(Ready),      32'(k > HOLD + STALL));
        check("ShortPulse", 32'(ShortPulse), 32'(sp));
        check("ResetCount", 32'(ResetCount), 32'(cnt));
        check("ResetCount2", 32'(ResetCount2), 32'((cnt > 3) ? 3 : cnt));
        check("ShortPulse2", 32'(ShortPulse2), 32'(sp));
    endtask

    task automatic pulse(input int hi, input int lo);
        for (int i = 0; i < hi; i++) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < lo; i++) step(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        // POR: edge 0 is the last reset edge, then the request stays low.
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b0);
        check("por_ready", 32'(Ready), 32'd1);
        check("por_count", 32'(ResetCount), 32'd0);

        pulse(20, 30);
        check("long_count", 32'(ResetCount), 32'd1);
        check("long_sp", 32'(ShortPulse), 32'd0);

        pulse(4, 30);
        check("short_sp", 32'(ShortPulse), 32'd1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        check("clear_sp", 32'(ShortPulse), 32'd0);

        // Re-assert inside HOLD and inside STALL.
        pulse(15, SYNC + 1 + 8);
        pulse(15, SYNC + 1 + HOLD + 3);
        pulse(15, 30);

        // Short pulse whose fall coincides with ClearErr: set must win.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        check("set_beats_clr", 32'(ShortPulse), 32'd1);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);

        // Reset mid-STALL, then POR timing again.
        pulse(20, SYNC + 1 + HOLD + 4);
        step(1'b0, 1'b0, 1'b0);
        check("rst_core", 32'(CoreBReset), 32'd1);
        check("rst_count", 32'(ResetCount), 32'd0);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b0);

        // Random episodes; widths avoid the MIN_ASSERT boundary region.
        for (int e = 0; e < 150; e++) begin
            int hi, lo;
            hi = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 6)) : int'($urandom_range(14, 25));
            lo = ($urandom_range(0, 3) == 0) ? int'($urandom_range(28, 40)) : int'($urandom_range(1, 27));
            for (int i = 0; i < hi; i++) step(1'b1, 1'b1, ($urandom_range(0, 7) == 0));
            for (int i = 0; i < lo; i++) begin
                if ($urandom_range(0, 199) == 0) step(1'b0, 1'b0, 1'b0);
                else step(1'b0, 1'b1, ($urandom_range(0, 7) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
